// File: rtl/pc_pkg.sv
// Shared CPU constants used by the program-counter slice.
package pc_pkg;

  // Address width of every PC bus.
  localparam int unsigned ADDR_W = 32;

  // Value the PC holds after reset.
  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

  // Branch is taken only when the instruction is a branch and the ALU reports zero.
  function automatic logic branch_taken(input logic branch, input logic zero);
    return branch & zero;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// 2:1 next-PC selector: sequential address or branch target.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] pcupdate,
  input  logic [WIDTH-1:0] pcbranch,
  input  logic             pcsrc,
  output logic [WIDTH-1:0] pcnext
);

  // Pick the branch target when taken, otherwise the fall-through address.
  always_comb begin
    pcnext = pcupdate;
    if (pcsrc) pcnext = pcbranch;
  end

endmodule

// File: rtl/pc.sv
// Program counter register. Inputs carry no handshake: every input is
// valid on every cycle and the register loads a new value on every edge.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch,
  input  logic             zero,
  input  logic [WIDTH-1:0] pcbranch,
  input  logic [WIDTH-1:0] pcupdate,
  output logic [WIDTH-1:0] pcupdated
);

  logic             pcsrc;
  logic [WIDTH-1:0] pcnext;

  // Branch condition; addresses pass through verbatim, no masking or increment.
  assign pcsrc = branch_taken(branch, zero);

  pc_next_mux #(
    .WIDTH(WIDTH)
  ) u_next_mux (
    .pcupdate(pcupdate),
    .pcbranch(pcbranch),
    .pcsrc   (pcsrc),
    .pcnext  (pcnext)
  );

  // PC register: synchronous reset wins, otherwise load the selected address.
  always_ff @(posedge clk) begin
    if (reset) pcupdated <= RESET_VALUE;
    else       pcupdated <= pcnext;
  end

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for the program counter.
module tb_pc;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         branch;
  logic         zero;
  logic [W-1:0] pcbranch;
  logic [W-1:0] pcupdate;
  logic [W-1:0] pcupdated;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  bit           model_live = 0;

  pc dut (
    .clk      (clk),
    .reset    (reset),
    .branch   (branch),
    .zero     (zero),
    .pcbranch (pcbranch),
    .pcupdate (pcupdate),
    .pcupdated(pcupdated)
  );

  // Clock and initial input values
  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    branch   = 1'b0;
    zero     = 1'b0;
    pcbranch = '0;
    pcupdate = '0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Model: what the PC must hold after each edge, from the input rules.
  always @(posedge clk) begin
    if (reset) model_live = 1;
    if (model_live) begin
      if (reset)                exp_q.push_back('0);
      else if (branch && zero)  exp_q.push_back(pcbranch);
      else                      exp_q.push_back(pcupdate);
    end
  end

  // Compare process: every low clock phase once the PC is defined.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (pcupdated !== e) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, pcupdated, e);
      end
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] exp);
    checks++;
    if (pcupdated !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, pcupdated, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the literal value after the edge.
  task automatic step(input string name, input logic r, input logic b, input logic z,
                      input logic [W-1:0] pb, input logic [W-1:0] pu,
                      input logic [W-1:0] exp);
    @(negedge clk);
    reset    = r;
    branch   = b;
    zero     = z;
    pcbranch = pb;
    pcupdate = pu;
    @(posedge clk);
    #1;
    check_lit(name, exp);
  endtask

  logic [W-1:0] held;

  initial begin
    step("reset",          1, 0, 0, 32'h4,         32'h8,         32'h0000_0000);
    step("seq_after_rst",  0, 0, 0, 32'h4,         32'h8,         32'h0000_0008);
    step("branch_taken",   0, 1, 1, 32'h4,         32'hC,         32'h0000_0004);
    step("branch_not_tk",  0, 1, 0, 32'h4,         32'h8,         32'h0000_0008);
    step("nobranch_zero1", 0, 0, 1, 32'h10,        32'h20,        32'h0000_0020);
    step("rst_priority",   1, 1, 1, 32'h4,         32'h8,         32'h0000_0000);
    step("resume_taken",   0, 1, 1, 32'h40,        32'h44,        32'h0000_0040);
    step("seq_top",        0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step("branch_odd",     0, 1, 1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF);
    step("seq_after_odd",  0, 0, 0, 32'h1234,      32'h0000_0100, 32'h0000_0100);

    // Reset pulse confined to the low clock phase must not disturb the PC.
    @(negedge clk);
    branch   = 1'b0;
    zero     = 1'b0;
    pcupdate = 32'h0000_0200;
    held     = pcupdated;
    #1 reset = 1'b1;
    #1;
    check_lit("rst_glitch_mid", held);
    reset = 1'b0;
    #1;
    check_lit("rst_glitch_after", held);
    @(posedge clk);
    #1;
    check_lit("post_glitch_seq", 32'h0000_0200);

    step("mid_reset",      1, 0, 0, 32'h4,         32'h300,       32'h0000_0000);
    step("resume_seq",     0, 0, 0, 32'h4,         32'h304,       32'h0000_0304);
    step("resume_branch",  0, 1, 1, 32'h800,       32'h308,       32'h0000_0800);

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameter WIDTH, default 32, address width of all PC buses.
REQ-002 Parameter RESET_VALUE, default 32'h0000_0000, value loaded into the PC on reset.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 branch  input  1  current instruction is a conditional branch.
REQ-006 zero  input  1  ALU zero flag; branch condition met when high.
REQ-007 pcbranch  input  WIDTH  branch target address.
REQ-008 pcupdate  input  WIDTH  sequential next address (PC+4, computed externally).
REQ-009 pcupdated  output  WIDTH  current registered program counter.

Function
REQ-010 The block SHALL hold one WIDTH-bit PC register driving pcupdated directly, with no combinational path from any input to pcupdated.
REQ-011 The block SHALL form pcsrc = branch AND zero.
REQ-012 When pcsrc=1 and reset=0, the PC SHALL load pcbranch at the next rising clk edge.
REQ-013 When pcsrc=0 and reset=0, the PC SHALL load pcupdate at the next rising clk edge.
REQ-014 branch=1 with zero=0 SHALL select pcupdate (branch not taken).
REQ-015 branch=0 SHALL select pcupdate regardless of zero.
REQ-016 Latency SHALL be exactly one clock: inputs sampled at edge N appear on pcupdated after edge N.
REQ-017 The PC SHALL update on every clock edge; there is no hold/enable input.
REQ-018 Addresses SHALL be loaded verbatim, with no alignment masking, increment or wrap logic inside the block; 32'hFFFF_FFFC etc. pass through unchanged.
REQ-019 No handshake; inputs are valid-every-cycle.

Reset
REQ-020 When reset=1 at a rising clk edge, pcupdated SHALL become RESET_VALUE (0x0000_0000) after that edge.
REQ-021 Reset SHALL take priority over branch, zero, pcbranch and pcupdate.
REQ-022 Reset SHALL be purely synchronous; an assertion between edges SHALL NOT change pcupdated until the next rising edge.
REQ-023 Reset asserted mid-operation (after normal updates) SHALL return the PC to RESET_VALUE on the next edge, and normal selection SHALL resume on the first edge with reset=0.
REQ-024 Before the first reset edge, pcupdated is undefined; the bench SHALL NOT check it.

Structure
REQ-025 WIDTH default and RESET_VALUE SHALL be defined as constants in the shared CPU package (e.g. ADDR_W, PC_RESET) and used as parameter defaults.
REQ-026 The next-PC selection SHALL be a separate 2:1 mux sub-module, pc_next_mux (inputs pcupdate, pcbranch, select pcsrc), instantiated inside pc; the register stays in pc.

Verification
REQ-027 reset=1 for one edge, pcbranch=0x4, pcupdate=0x8 -> pcupdated=0x0000_0000 after the edge.
REQ-028 reset=0, branch=0, zero=0, pcupdate=0x8 -> pcupdated=0x0000_0008 one edge later.
REQ-029 branch=1, zero=1, pcbranch=0x4 -> pcupdated=0x0000_0004 one edge later.
REQ-030 branch=1, zero=0, pcupdate=0x8 -> pcupdated=0x0000_0008 (not taken).
REQ-031 reset=1 together with branch=1, zero=1 -> pcupdated=0x0000_0000; deassert reset -> next edge loads selected address.
REQ-032 reset pulsed between clock edges with no rising edge during the pulse -> pcupdated unchanged.
